// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and fetch bundle.
// Used by the fetch stage and its instruction buffer.
package cpu_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 29;
  localparam int FE_W    = ADDR_W + INSTR_W;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fe_entry_t;

  function automatic pc_t pc_inc(pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush.
// Head entry is visible on rdata while not empty.
module fetch_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_pop;
  logic w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign rdata  = r_mem[r_rptr];

  // Pointer and occupancy tracking; flush empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM address, and
// buffered hand-off to decode with redirect flush.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 11'h000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  logic [ADDR_W-1:0] r_pc;

  logic      w_full;
  logic      w_empty;
  logic      w_pop;
  logic      w_push;
  fe_entry_t w_wr;
  fe_entry_t w_rd;

  assign rom_addr  = r_pc;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign w_push    = fetch_en & ~redirect_valid
                   & (~w_full | w_pop);

  assign w_wr.pc    = r_pc;
  assign w_wr.instr = rom_data;

  assign out_pc    = out_valid ? w_rd.pc    : '0;
  assign out_instr = out_valid ? w_rd.instr : '0;

  // PC: redirect wins, else advance on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc <= pc_inc(r_pc);
    end
  end

  fetch_fifo #(
    .WIDTH (FE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (w_push),
    .wdata (w_wr),
    .pop   (w_pop),
    .rdata (w_rd),
    .empty (w_empty),
    .full  (w_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch.
// Expected PCs are queued per scenario and popped on handshake.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               fetch_en;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (11'h000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  function automatic logic [INSTR_W-1:0] rom_word(logic [ADDR_W-1:0] a);
    return {a ^ 11'h2A5, a[6:0] ^ 7'h5B, a ^ 11'h13C};
  endfunction

  assign rom_data = rom_word(rom_addr);

  int n_chk  = 0;
  int n_fail = 0;
  logic [ADDR_W-1:0] q[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while (q.size() != 0 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  bit                hold;
  logic [ADDR_W-1:0] hold_pc;
  logic [ADDR_W-1:0] e;

  // Scoreboard: consume expectations on every accepted word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && hold)
        chk("hold_pc", 32'(out_pc), 32'(hold_pc));
      if (out_valid && out_ready) begin
        chk("q_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("acc_pc", 32'(out_pc), 32'(e));
          chk("acc_instr", 32'(out_instr), 32'(rom_word(e)));
        end
      end
      hold    = out_valid && !out_ready;
      hold_pc = out_pc;
    end else begin
      hold = 1'b0;
    end
  end

  int cyc;

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'h000);
    tick();
    tick();

    // Streaming from reset: 0,1,2,3 back to back.
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    q = '{11'h000, 11'h001, 11'h002, 11'h003};
    rst_n = 1'b1;
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_pc", 32'(out_pc), 32'h000);
    drain(cyc);
    chk("stream_cycles", 32'(cyc), 32'd4);
    out_ready = 1'b0;

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", 32'(out_pc), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'h000);
    tick();

    // Backpressure: fill, hold PC, release in order.
    rst_n = 1'b1;
    repeat (5) tick();
    chk("bp_addr", 32'(rom_addr), 32'h002);
    chk("bp_pc", 32'(out_pc), 32'h000);
    chk("bp_valid", 32'(out_valid), 32'd1);
    q = '{11'h000, 11'h001, 11'h002, 11'h003};
    out_ready = 1'b1;
    drain(cyc);
    chk("bp_cycles", 32'(cyc), 32'd4);
    out_ready = 1'b0;

    // Redirect with two stale entries buffered.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 11'h025;
    tick();
    redirect_valid = 1'b0;
    chk("rd_bubble", 32'(out_valid), 32'd0);
    q = '{11'h025, 11'h026};
    out_ready = 1'b1;
    tick();
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_pc", 32'(out_pc), 32'h025);
    drain(cyc);
    out_ready = 1'b0;

    // Redirect near top of address space: wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 11'h7FE;
    tick();
    redirect_valid = 1'b0;
    chk("wr_bubble", 32'(out_valid), 32'd0);
    q = '{11'h7FE, 11'h7FF, 11'h000};
    out_ready = 1'b1;
    drain(cyc);
    chk("wr_cycles", 32'(cyc), 32'd4);
    out_ready = 1'b0;

    // Pop coincident with redirect.
    repeat (3) tick();
    chk("pr_head", 32'(out_pc), 32'h001);
    q = '{11'h001, 11'h100, 11'h101};
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 11'h100;
    tick();
    redirect_valid = 1'b0;
    chk("pr_bubble", 32'(out_valid), 32'd0);
    chk("pr_once", 32'(q.size()), 32'd2);
    drain(cyc);
    chk("pr_cycles", 32'(cyc), 32'd3);
    out_ready = 1'b0;

    // fetch_en low: redirect applies, no pushes, buffer drains.
    fetch_en       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 11'h200;
    tick();
    redirect_valid = 1'b0;
    chk("fe_addr", 32'(rom_addr), 32'h200);
    tick();
    tick();
    chk("fe_idle_valid", 32'(out_valid), 32'd0);
    chk("fe_idle_addr", 32'(rom_addr), 32'h200);
    fetch_en = 1'b1;
    tick();
    tick();
    fetch_en = 1'b0;
    q = '{11'h200, 11'h201};
    out_ready = 1'b1;
    drain(cyc);
    chk("fe_cycles", 32'(cyc), 32'd2);
    tick();
    chk("fe_empty", 32'(out_valid), 32'd0);
    chk("fe_hold_addr", 32'(rom_addr), 32'h202);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
